// File: rtl/tqvp_cattuto_ws2812b_multi.sv
// Multi-channel WS2812B strip driver: one shared serial bit stream gated per channel by a mask sampled at start.
// Optional macro WS2812B_BRIGHTNESS_EN scales each colour byte by BRIGHT at pixel load.
module tqvp_cattuto_ws2812b_multi #(
    parameter int NUM_CH = 2,
    parameter int T_BIT  = 80,
    parameter int T0H    = 26,
    parameter int T1H    = 51,
    parameter int T_RES  = 3840
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int CMAX = (T_BIT > T_RES) ? T_BIT : T_RES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

    state_t              state, state_d;
    logic                ready;
    logic [7:0]          g_q, r_q, b_q;
    logic [NUM_CH-1:0]   chmask, act_mask, out_q;
    logic [5:0]          count, count_d;
    logic                latch_q, set_q;
    logic [23:0]         shift, shift_d, pix_word;
    logic [4:0]          bit_idx, bit_idx_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic                wr_ok, ctrl_wr;

    wire unused_ok = &{1'b0, ui_in};

    assign wr_ok   = data_write && ready;
    assign ctrl_wr = wr_ok && (address == 4'd0);

`ifdef WS2812B_BRIGHTNESS_EN
    logic [7:0] bright;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] k);
        logic [16:0] p;
        p = 17'(c) * 17'({1'b0, k} + 9'd1);
        return p[15:8];
    endfunction

    assign pix_word = set_q ? {scale(g_q, bright), scale(r_q, bright), scale(b_q, bright)} : 24'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             bright <= 8'hFF;
        else if (wr_ok && address == 4'd6)      bright <= data_in;
    end
`else
    assign pix_word = set_q ? {g_q, r_q, b_q} : 24'h0;
`endif

    // Counters load "duration - 1" so a phase ends on the cycle cnt reads zero.
    function automatic logic [CW-1:0] hi_len(input logic b);
        return b ? CW'(T1H - 1) : CW'(T0H - 1);
    endfunction

    function automatic logic [CW-1:0] lo_len(input logic b);
        return b ? CW'(T_BIT - T1H - 1) : CW'(T_BIT - T0H - 1);
    endfunction

    always_comb begin
        state_d   = state;
        count_d   = count;
        shift_d   = shift;
        bit_idx_d = bit_idx;
        cnt_d     = cnt;
        case (state)
            IDLE: if (ctrl_wr) state_d = LOAD;
            LOAD: begin
                if (count != 6'd0) begin
                    state_d   = HIGH;
                    shift_d   = pix_word;
                    bit_idx_d = 5'd23;
                    cnt_d     = hi_len(pix_word[23]);
                end else if (latch_q) begin
                    state_d = LATCH;
                    cnt_d   = CW'(T_RES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_d = LOW;
                    cnt_d   = lo_len(shift[23]);
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            LOW: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else if (bit_idx == 5'd0) begin
                    state_d = LOAD;
                    count_d = count - 6'd1;
                end else begin
                    state_d   = HIGH;
                    shift_d   = {shift[22:0], 1'b0};
                    bit_idx_d = bit_idx - 5'd1;
                    cnt_d     = hi_len(shift[22]);
                end
            end
            LATCH: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the next state so outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            out_q <= '0;
        end else begin
            state <= state_d;
            ready <= (state_d == IDLE);
            out_q <= (state_d == HIGH) ? act_mask : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q      <= 8'h00;
            r_q      <= 8'h00;
            b_q      <= 8'h00;
            chmask   <= NUM_CH'(1);
            act_mask <= NUM_CH'(1);
            count    <= 6'd0;
            latch_q  <= 1'b0;
            set_q    <= 1'b0;
            shift    <= 24'h0;
            bit_idx  <= 5'd0;
            cnt      <= '0;
        end else begin
            shift   <= shift_d;
            bit_idx <= bit_idx_d;
            cnt     <= cnt_d;
            count   <= count_d;
            if (wr_ok) begin
                case (address)
                    4'd1: g_q    <= data_in;
                    4'd2: r_q    <= data_in;
                    4'd3: b_q    <= data_in;
                    4'd5: chmask <= data_in[NUM_CH-1:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                latch_q  <= data_in[7];
                set_q    <= data_in[6];
                count    <= data_in[5:0];
                act_mask <= chmask;
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'd0: data_out = {7'b0, ready};
            4'd5: data_out[NUM_CH-1:0] = chmask;
            default: ;
        endcase
    end

    always_comb begin
        uo_out = 8'h00;
        uo_out[NUM_CH:1] = out_q;
    end

endmodule

// File: doc/tqvp_cattuto_ws2812b_multi.md
TQVP_CATTUTO_WS2812B_MULTI -- requirements
Module: tqvp_cattuto_ws2812b_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent strip outputs (1..6).
REQ-002 SHALL have parameter T_BIT, default 80, bit period in clk cycles (1.25 us at 64 MHz).
REQ-003 SHALL have parameter T0H, default 26, and T1H, default 51: high time in cycles for a 0 bit and a 1 bit.
REQ-004 SHALL have parameter T_RES, default 3840, latch low time in cycles (60 us).
REQ-005 SHALL have port clk, input, 1, project clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ui_in, input, 8, unused and ignored.
REQ-008 SHALL have port uo_out, output, 8; bits [NUM_CH:1] drive the strips, all other bits constant 0.
REQ-009 SHALL have port address, input, 4, register select.
REQ-010 SHALL have port data_write, input, 1, single-cycle write strobe.
REQ-011 SHALL have port data_in, input, 8, write data.
REQ-012 SHALL have port data_out, output, 8, combinational read data.

Function
REQ-013 Register map: 0 CTRL (W: bit7 latch, bit6 set/clear, bits5:0 pixel count); 1 G; 2 R; 3 B; 5 CHMASK (bits [NUM_CH-1:0]); 6 BRIGHT.
REQ-014 Read of address 0 SHALL return {7'b0, ready}; address 5 SHALL return CHMASK; all other addresses SHALL return 0.
REQ-015 While ready=0, all writes SHALL be ignored, including writes to G/R/B/CHMASK/BRIGHT.
REQ-016 A CTRL write with ready=1 SHALL clear ready on the next edge and start the FSM in LOAD.
REQ-017 FSM states: IDLE, LOAD, HIGH, LOW, LATCH.
REQ-018 Transitions: IDLE->LOAD on CTRL write; LOAD->HIGH if count>0; LOAD->LATCH if count=0 and latch=1; LOAD->IDLE if count=0 and latch=0.
REQ-019 LOAD SHALL capture pixel word = set ? {G,R,B} : 24'h0, sent MSB first (G7 first).
REQ-020 Each bit SHALL be high T0H or T1H cycles (HIGH), then low for T_BIT minus high time (LOW); exactly T_BIT cycles per bit.
REQ-021 After bit 0 of a pixel, count SHALL decrement and the FSM SHALL return to LOAD.
REQ-022 LOAD SHALL last one cycle; inter-pixel low gap SHALL therefore be 1 cycle longer than an intra-pixel bit low.
REQ-023 LATCH SHALL hold all enabled outputs low for T_RES cycles, then go to IDLE.
REQ-024 Entering IDLE SHALL set ready=1 on the same edge.
REQ-025 Output for channel i SHALL equal the serial bit AND CHMASK[i]; masked channels SHALL stay low throughout.
REQ-026 CHMASK SHALL be sampled at CTRL write; later changes SHALL NOT affect a transfer in progress.
REQ-027 Outputs SHALL be registered and glitch-free; no output transition other than at bit boundaries and high-time ends.
REQ-028 Cycle counter width SHALL be $clog2 of max(T_BIT, T_RES)+1.

Reset
REQ-029 rst_n low SHALL asynchronously force FSM=IDLE, ready=1, all uo_out=0, G=R=B=0, CHMASK=1, BRIGHT=8'hFF, count=0.
REQ-030 Reset mid-transfer SHALL abort immediately; no residual pulse after rst_n rises.

Configuration
REQ-031 Macro WS2812B_BRIGHTNESS_EN defined: LOAD SHALL send each colour byte as (byte*(BRIGHT+1))>>8, truncated to 8 bits.
REQ-032 Macro WS2812B_BRIGHTNESS_EN undefined: no multiplier, raw bytes sent, writes to address 6 ignored, reads of 6 return 0.

Verification
REQ-033 G=0x80,R=0x00,B=0x01, CHMASK=1, CTRL=0x41 -> ch0: 24 bits in 1920 cycles, first bit high 51 cycles, bits 2..23 high 26, last high 51; ready returns to 1.
REQ-034 CTRL=0x80 (count 0, latch) -> all enabled outputs low for 3840 cycles, ready=0 throughout, then ready=1.
REQ-035 CHMASK=0b10, CTRL=0x43 -> uo_out[2] carries 3 pixels (72 bits), uo_out[1] stays 0; CTRL write during transfer ignored.
REQ-036 Assert rst_n low at bit 10 of pixel 2 -> uo_out=0 within the same cycle, ready=1, no further pulses.
REQ-037 With WS2812B_BRIGHTNESS_EN, BRIGHT=0x7F, G=R=B=0xFF, CTRL=0x41 -> transmitted word 0x7F7F7F; without macro -> 0xFFFFFF.
